// File: rtl/demod_bit_framer_if.sv
// rtl/demod_bit_framer_if.sv - byte output stream bundle for demod_bit_framer
//
// Carries the framed payload bytes from the framer FIFO head to the packet layer.
//   byte_out     payload byte at FIFO head
//   byte_valid   FIFO non-empty
//   byte_ready   consumer accepts; transfer on byte_valid & byte_ready
//   frame_start  byte_out is the first byte of a frame
//   frame_end    byte_out is the last byte of a frame
// master: the framer (drives data/flags), slave: the consumer (drives byte_ready).

interface demod_bit_framer_if;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       byte_ready;
    logic       frame_start;
    logic       frame_end;

    modport master (
        output byte_out,
        output byte_valid,
        output frame_start,
        output frame_end,
        input  byte_ready
    );

    modport slave (
        input  byte_out,
        input  byte_valid,
        input  frame_start,
        input  frame_end,
        output byte_ready
    );
endinterface

// File: rtl/demod_bit_framer.sv
// rtl/demod_bit_framer.sv - integrate-and-dump bit slicer, sync hunter and byte framer
//
// Integrates SAMPLES_PER_BIT signed samples per hard bit decision, hunts for
// SYNC_WORD in the decided bit stream, then packs FRAME_BYTES payload bytes
// (MSB first) into a 4-entry FIFO with start/end sideband flags.
//
// Ports:
//   clk           clock, rising edge
//   rst           asynchronous active-high reset
//   sample_in     signed 16-bit demodulator sample
//   sample_valid  sample_in valid this cycle
//   locked        high while a frame payload is being collected
//   overflow      one-cycle pulse when a completed byte is dropped (FIFO full)
//   bytes         demod_bit_framer_if.master byte stream (byte_out/byte_valid/
//                 byte_ready/frame_start/frame_end)
//
// Build option DEMOD_SYNC_ERR_TOL_EN: sync match accepts a Hamming distance of
// up to 1; the distance is registered, adding one cycle of lock latency.

module demod_bit_framer #(
    parameter int          SAMPLES_PER_BIT = 4,
    parameter logic [31:0] SYNC_WORD       = 32'h1ACFFC1D,
    parameter int          FRAME_BYTES     = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic signed [15:0]  sample_in,
    input  logic                sample_valid,
    output logic                locked,
    output logic                overflow,
    demod_bit_framer_if.master  bytes
);

    localparam int ACC_W  = 16 + $clog2(SAMPLES_PER_BIT);
    localparam int SCNT_W = $clog2(SAMPLES_PER_BIT);

    typedef enum logic {HUNT, DATA} state_t;

    // ---------------- integrate and dump ----------------
    logic signed [ACC_W-1:0]  acc_q;
    logic        [SCNT_W-1:0] scnt_q;
    logic signed [ACC_W-1:0]  acc_sum;
    logic                     bit_valid;
    logic                     bit_val;

    assign acc_sum   = acc_q + {{(ACC_W-16){sample_in[15]}}, sample_in};
    assign bit_valid = sample_valid && (scnt_q == SCNT_W'(SAMPLES_PER_BIT - 1));
    // Strictly positive sum decides 1; zero decides 0.
    assign bit_val   = !acc_sum[ACC_W-1] && (|acc_sum);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q  <= '0;
            scnt_q <= '0;
        end else if (sample_valid) begin
            if (bit_valid) begin
                acc_q  <= '0;
                scnt_q <= '0;
            end else begin
                acc_q  <= acc_sum;
                scnt_q <= scnt_q + SCNT_W'(1);
            end
        end
    end

    // ---------------- sync hunt / framing FSM ----------------
    state_t      state_q, next_state;
    logic [31:0] sreg_q;
    logic [2:0]  bit_cnt_q;
    logic [7:0]  byte_cnt_q;
    logic        sync_match;
    logic        byte_done;
    logic        last_byte;
    logic        push;
    logic [9:0]  push_data;

`ifdef DEMOD_SYNC_ERR_TOL_EN
    function automatic logic [5:0] popcount32(input logic [31:0] v);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < 32; i++) begin
            c = c + 6'(v[i]);
        end
        return c;
    endfunction

    logic [5:0] hd_q;
    logic       hd_live_q;

    // hd_live_q masks the first HUNT cycle, whose distance was computed from
    // the payload still in the shift register before it was cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hd_q      <= 6'd32;
            hd_live_q <= 1'b0;
        end else begin
            hd_q      <= popcount32(sreg_q ^ SYNC_WORD);
            hd_live_q <= (state_q == HUNT);
        end
    end

    assign sync_match = hd_live_q && (hd_q <= 6'd1);
`else
    assign sync_match = (sreg_q == SYNC_WORD);
`endif

    assign byte_done = bit_valid && (bit_cnt_q == 3'd7);
    assign last_byte = (byte_cnt_q == 8'(FRAME_BYTES - 1));
    assign push_data = {sreg_q[6:0], bit_val, (byte_cnt_q == 8'd0), last_byte};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= HUNT;
        end else begin
            state_q <= next_state;
        end
    end

    always_comb begin
        next_state = state_q;
        push       = 1'b0;
        case (state_q)
            HUNT: begin
                if (sync_match) begin
                    next_state = DATA;
                end
            end
            DATA: begin
                if (byte_done) begin
                    push = 1'b1;
                    if (last_byte) begin
                        next_state = HUNT;
                    end
                end
            end
            default: next_state = HUNT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg_q     <= '0;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
        end else begin
            // Clearing on HUNT entry keeps payload bits out of the next sync search.
            if (state_q == DATA && next_state == HUNT) begin
                sreg_q <= '0;
            end else if (bit_valid) begin
                sreg_q <= {sreg_q[30:0], bit_val};
            end

            if (state_q == HUNT && next_state == DATA) begin
                // A bit decided on the lock edge is already the first payload bit.
                bit_cnt_q  <= bit_valid ? 3'd1 : 3'd0;
                byte_cnt_q <= '0;
            end else if (state_q == DATA && bit_valid) begin
                bit_cnt_q <= bit_cnt_q + 3'd1;
                if (byte_done) begin
                    byte_cnt_q <= byte_cnt_q + 8'd1;
                end
            end
        end
    end

    // ---------------- output FIFO ----------------
    logic [9:0] mem [4];
    logic [1:0] wr_q, rd_q;
    logic [2:0] cnt_q;
    logic       full, empty, pop, accept;
    logic [9:0] head;

    assign full   = (cnt_q == 3'd4);
    assign empty  = (cnt_q == 3'd0);
    assign pop    = !empty && bytes.byte_ready;
    assign accept = push && (!full || pop);
    assign head   = mem[rd_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                mem[i] <= '0;
            end
            wr_q     <= '0;
            rd_q     <= '0;
            cnt_q    <= '0;
            overflow <= 1'b0;
        end else begin
            if (accept) begin
                mem[wr_q] <= push_data;
                wr_q      <= wr_q + 2'd1;
            end
            if (pop) begin
                rd_q <= rd_q + 2'd1;
            end
            case ({accept, pop})
                2'b10:   cnt_q <= cnt_q + 3'd1;
                2'b01:   cnt_q <= cnt_q - 3'd1;
                default: cnt_q <= cnt_q;
            endcase
            overflow <= push && full && !pop;
        end
    end

    assign bytes.byte_valid  = !empty;
    assign bytes.byte_out    = empty ? 8'd0 : head[9:2];
    assign bytes.frame_start = !empty && head[1];
    assign bytes.frame_end   = !empty && head[0];
    assign locked            = (state_q == DATA);

endmodule

// File: tb/tb_demod_bit_framer.sv
// tb/tb_demod_bit_framer.sv - scoreboard bench for demod_bit_framer

module tb_demod_bit_framer;

    localparam int          SPB  = 4;
    localparam logic [31:0] SYNC = 32'h1ACFFC1D;
    localparam int          FB   = 16;
`ifdef DEMOD_SYNC_ERR_TOL_EN
    localparam int TOL = 1;
    localparam int LOCK_LAT = 3;
`else
    localparam int TOL = 0;
    localparam int LOCK_LAT = 2;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic signed [15:0] sample_in;
    logic               sample_valid;
    logic               locked;
    logic               overflow;

    demod_bit_framer_if bus ();

    demod_bit_framer dut (
        .clk          (clk),
        .rst          (rst),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .locked       (locked),
        .overflow     (overflow),
        .bytes        (bus)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;
    logic [9:0] sb[$];

    // reference model state
    bit          m_data;
    logic [31:0] m_win;
    logic [7:0]  m_cur;
    int          m_nbits, m_nbytes;
    int          exp_frames = 0, exp_ovf = 0;
    bit          bp = 0;

    int  lock_cnt = 0, ovf_cnt = 0;
    int  ready_mode = 1;
    bit  gaps = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_data = 0; m_win = '0; m_nbits = 0; m_nbytes = 0; m_cur = '0;
    endfunction

    function automatic void model_bit(input logic b);
        if (!m_data) begin
            m_win = {m_win[30:0], b};
            if ($countones(m_win ^ SYNC) <= TOL) begin
                m_data = 1; m_nbits = 0; m_nbytes = 0;
                exp_frames++;
            end
        end else begin
            m_cur = {m_cur[6:0], b};
            m_nbits++;
            if (m_nbits == 8) begin
                m_nbits = 0;
                if (bp && sb.size() >= 4) exp_ovf++;
                else sb.push_back({m_cur, m_nbytes == 0, m_nbytes == FB - 1});
                m_nbytes++;
                if (m_nbytes == FB) begin
                    m_data = 0;
                    m_win  = '0;
                end
            end
        end
    endfunction

    task automatic idle(input int n);
        sample_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drive_sample(input int s);
        if (gaps) begin
            while ($urandom_range(0, 3) == 0) begin
                sample_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        sample_in    = 16'(s);
        sample_valid = 1'b1;
        @(posedge clk); #1;
        sample_valid = 1'b0;
    endtask

    task automatic send_group(input int a, input int b, input int c, input int d, input logic exp_bit);
        drive_sample(a); drive_sample(b); drive_sample(c); drive_sample(d);
        model_bit(exp_bit);
    endtask

    task automatic send_bit(input logic b, input bit pm);
        int s, sum, target;
        sum = 0;
        if (pm) begin
            for (int i = 0; i < SPB; i++) drive_sample(b ? 1000 : -1000);
        end else begin
            for (int i = 0; i < SPB - 1; i++) begin
                s = int'($urandom_range(0, 4000)) - 2000;
                sum += s;
                drive_sample(s);
            end
            target = b ? int'($urandom_range(1, 3000)) : -int'($urandom_range(0, 3000));
            drive_sample(target - sum);
        end
        model_bit(b);
    endtask

    task automatic send_word(input logic [31:0] w, input bit pm);
        for (int i = 31; i >= 0; i--) send_bit(w[i], pm);
    endtask

    task automatic send_byte(input logic [7:0] v, input bit pm);
        for (int i = 7; i >= 0; i--) send_bit(v[i], pm);
    endtask

    task automatic send_rand_bytes(input int n);
        for (int i = 0; i < n; i++) send_byte(8'($urandom), 1'b0);
    endtask

    task automatic drain_check(input string name);
        int k;
        k = 0;
        while (sb.size() != 0 && k < 500) begin @(posedge clk); #1; k++; end
        check(name, sb.size(), 0);
    endtask

    // byte_ready driver
    initial begin
        bus.byte_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       bus.byte_ready = 1'b0;
                1:       bus.byte_ready = 1'b1;
                default: bus.byte_ready = ($urandom_range(0, 9) < 7);
            endcase
        end
    end

    // monitor / scoreboard
    initial begin
        logic       prev_stall, prev_locked;
        logic [9:0] prev_head, e;
        prev_stall = 0; prev_locked = 0; prev_head = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 0;
                prev_locked = 0;
            end else begin
                if (overflow) ovf_cnt++;
                if (locked && !prev_locked) lock_cnt++;
                prev_locked = locked;
                if (prev_stall)
                    check("hold_stable", {bus.byte_valid, bus.byte_out, bus.frame_start, bus.frame_end},
                          {1'b1, prev_head});
                if (bus.byte_valid && bus.byte_ready) begin
                    if (sb.size() == 0) begin
                        vectors++;
                        errors++;
                        $display("FAIL unexpected_byte: got %h expected none at %0t",
                                 {bus.byte_out, bus.frame_start, bus.frame_end}, $time);
                    end else begin
                        e = sb.pop_front();
                        check("byte_flags", {bus.byte_out, bus.frame_start, bus.frame_end}, e);
                    end
                end
                prev_stall = bus.byte_valid && !bus.byte_ready;
                prev_head  = {bus.byte_out, bus.frame_start, bus.frame_end};
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, l0, o0;
        model_reset();
        rst = 1'b1; sample_valid = 1'b0; sample_in = '0;
        @(negedge clk);
        check("rst_byte_out", bus.byte_out, 0);
        check("rst_byte_valid", bus.byte_valid, 0);
        check("rst_frame_start", bus.frame_start, 0);
        check("rst_frame_end", bus.frame_end, 0);
        check("rst_locked", locked, 0);
        check("rst_overflow", overflow, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);

        // lock and frame, ready held high
        send_word(SYNC, 1'b1);
        lat = 0;
        for (int k = 1; k <= 6 && lat == 0; k++) begin
            @(negedge clk);
            if (locked) lat = k;
        end
        check("lock_latency", lat, LOCK_LAT);
        @(posedge clk); #1;
        for (int i = 0; i < FB; i++) send_byte(8'(i), 1'b1);
        idle(10);
        check("unlock_after_frame", locked, 0);
        check("frame1_drained", sb.size(), 0);
        check("frame1_locks", lock_cnt, 1);

        // sign rule inside a frame: sums -1, 0 decide 0; +1 decides 1
        send_word(SYNC, 1'b0);
        send_group(3, 3, -2, -5, 1'b0);
        send_group(1, -1, 2, -2, 1'b0);
        send_group(1, 0, 0, 0, 1'b1);
        for (int i = 0; i < 5; i++) send_bit(1'($urandom), 1'b0);
        send_rand_bytes(FB - 1);
        idle(10);
        check("sign_frame_drained", sb.size(), 0);

        // backpressure: 4 buffered, 12 dropped
        ready_mode = 0; idle(3); bp = 1;
        o0 = ovf_cnt;
        send_word(SYNC, 1'b1);
        for (int i = 0; i < FB; i++) send_byte(8'(i), 1'b1);
        idle(10);
        check("bp_overflow_pulses", ovf_cnt - o0, 12);
        check("bp_model_overflow", ovf_cnt, exp_ovf);
        check("bp_fifo_depth", sb.size(), 4);
        bp = 0; ready_mode = 1;
        idle(20);
        check("bp_drained", sb.size(), 0);

        // sync error tolerance
        l0 = lock_cnt;
        send_word(SYNC ^ 32'h0000_0080, 1'b0);
        send_rand_bytes(FB);
        idle(40);
        check("tol_one_bit_lock", lock_cnt - l0, TOL);
        check("tol_one_bit_bytes", sb.size(), 0);
        l0 = lock_cnt;
        send_word(SYNC ^ 32'h0010_0080, 1'b0);
        send_rand_bytes(FB);
        idle(40);
        check("tol_two_bit_lock", lock_cnt - l0, 0);

        // reset mid-frame, with bytes buffered
        ready_mode = 0; idle(3); bp = 1;
        send_word(SYNC, 1'b1);
        for (int i = 0; i < 5; i++) send_byte(8'(i + 8'h40), 1'b1);
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("midrst_byte_valid", bus.byte_valid, 0);
        check("midrst_locked", locked, 0);
        sb.delete();
        model_reset();
        bp = 0; ready_mode = 1;
        @(posedge clk); #1;
        idle(2);
        rst = 1'b0;
        l0 = lock_cnt;
        send_rand_bytes(4);
        idle(20);
        check("postrst_no_lock", lock_cnt - l0, 0);
        send_word(SYNC, 1'b0);
        send_rand_bytes(FB);
        idle(20);
        check("postrst_relock", lock_cnt - l0, 1);

        // randomized frames with noise, gaps and random ready
        gaps = 1; ready_mode = 2;
        for (int f = 0; f < 5; f++) begin
            for (int i = 0; i < int'($urandom_range(0, 40)); i++) send_bit(1'($urandom), 1'b0);
            send_word(SYNC, 1'b0);
            send_rand_bytes(FB);
        end
        gaps = 0; ready_mode = 1;
        idle(5);
        drain_check("final_drain");
        check("final_lock_count", lock_cnt, exp_frames);
        check("final_overflow_count", ovf_cnt, exp_ovf);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/demod_bit_framer.md
# demod_bit_framer

Downstream stage of the digital demodulator. Consumes the 16-bit signed demodulated baseband samples, integrates and dumps them into hard bit decisions, and hunts for a sync word. Once locked, it packs a fixed-length frame into bytes and delivers them through a 4-entry output FIFO with a valid/ready handshake to the packet layer.

## Interface
- SAMPLES_PER_BIT, 4, valid samples integrated per bit decision (≥2).
- SYNC_WORD, 32'h1ACFFC1D, frame sync pattern, MSB received first.
- FRAME_BYTES, 16, payload bytes per frame after sync (1..255).
- clk  input  1  clock; all logic rising-edge.
- rst  input  1  asynchronous, active-high reset.
- sample_in  input  16  signed demodulator output (two's complement).
- sample_valid  input  1  sample_in valid this cycle; at most one sample per cycle.
- byte_out  output  8  payload byte at FIFO head.
- byte_valid  output  1  FIFO non-empty.
- byte_ready  input  1  consumer accepts; transfer on byte_valid & byte_ready.
- frame_start  output  1  qualifies byte_out as first byte of frame.
- frame_end  output  1  qualifies byte_out as last byte of frame.
- locked  output  1  high while in DATA state.
- overflow  output  1  one-cycle pulse when a completed byte is dropped.

## Operation
- Integrator: signed accumulator, width 16+clog2(SAMPLES_PER_BIT), no saturation. Adds sample_in on each sample_valid. sample_valid low holds the accumulator.
- Dump: on the SAMPLES_PER_BIT-th accepted sample, bit = 1 if (acc + sample_in) > 0, else 0 (zero sum gives 0). The accumulator reloads to 0 at the same edge.
- Each decided bit shifts into a 32-bit shift register, LSB in, MSB-first order.
- FSM states:
  - HUNT: after each bit shift, compare the shift register to SYNC_WORD. On match, go to DATA with bit_cnt=0 and byte_cnt=0.
  - DATA: count bits. Every 8th bit forms a byte from the last 8 bits received, MSB first, and pushes it into the FIFO. Sideband flags are frame_start (byte_cnt==0) and frame_end (byte_cnt==FRAME_BYTES-1). After the FRAME_BYTES-th byte is pushed, go to HUNT.
- HUNT clears the shift register on entry, so frame payload can never alias a sync match.
- FIFO: 4 entries × 10 bits (byte, start, end).
- Push while full with no pop in the same cycle: byte dropped, overflow pulses for one cycle, and the FSM continues counting (the frame stays aligned).
- Push while full with a pop in the same cycle: accepted.
- Reset (any time, including mid-frame): accumulator, counters, shift register and FIFO are cleared, FSM goes to HUNT. Outputs reset to 0: byte_out=0, byte_valid=0, frame_start=0, frame_end=0, locked=0, overflow=0.

## Timing
- Bit decision is visible in the shift register 1 cycle after the edge accepting the final sample of that bit.
- locked rises 1 cycle after the shift register equals SYNC_WORD, i.e. 2 cycles after the final sync sample edge.
- The byte push occurs on the edge that shifts in its 8th bit. byte_valid rises on the following cycle, provided the FIFO was empty.
- locked falls on the cycle after the last byte is pushed.
- Throughput: one sample per clock sustained. The FIFO drains at one byte per clock when byte_ready is held high.
- byte_out, frame_start and frame_end are stable while byte_valid & !byte_ready.

## Configuration
- DEMOD_SYNC_ERR_TOL_EN defined: HUNT matches when Hamming distance(shift register, SYNC_WORD) ≤ 1. The popcount is registered, so locked rises 3 cycles after the final sync sample edge.
- DEMOD_SYNC_ERR_TOL_EN undefined: exact match only, with the 2-cycle timing above.

## Test plan
- Reset: assert rst mid-stream → all outputs 0 immediately (async). After release, no lock until a full SYNC_WORD is received.
- Sign rule: SAMPLES_PER_BIT=4, samples +3,+3,-2,-5 (sum -1) → bit 0; samples +1,-1,+2,-2 (sum 0) → bit 0; samples +1,0,0,0 → bit 1.
- Lock and frame: send 32'h1ACFFC1D as ±1000 samples, then bytes 0x00..0x0F, byte_ready=1 → locked 2 cycles after the last sync sample; bytes 0x00..0x0F in order; frame_start only on 0x00, frame_end only on 0x0F; locked=0 afterwards.
- Backpressure: same frame with byte_ready=0 → 4 bytes buffered, overflow pulses once for each of bytes 0x04..0x0F. Then set byte_ready=1 → 0x00..0x03 delivered, with frame_start on 0x00.
- Sync tolerance: sync word with bit 7 flipped → no lock without DEMOD_SYNC_ERR_TOL_EN, lock with it. Two bits flipped → no lock in either build.
- Reset mid-frame: assert rst while byte 5 is being received → FIFO empty and locked=0. Payload bytes fed after release produce no byte_valid until a new sync word is received.
